// File: rtl/bus_memory_model.sv
// Unified main-memory model on the processor bus: one load/store accepted per cycle,
// tagged from a pool of 15, completing a fixed LATENCY cycles later.
module bus_memory_model #(
  parameter int MEM_LINES = 8192,
  parameter int LATENCY   = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [31:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  input  logic [1:0]  proc2mem_size,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  typedef enum logic [1:0] {CMD_NONE, CMD_LOAD, CMD_STORE, CMD_RESERVED} command_t;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DOUBLE} size_t;

  localparam int         LINE_BITS  = $clog2(MEM_LINES);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_LINES) * 33'd8;

  // Left unreset and directly addressable so program images can be preloaded.
  logic [63:0] unified_memory [MEM_LINES];

  logic [15:1]          busy;
  logic [3:0]           pipe_tag  [LATENCY];
  logic [63:0]          pipe_data [LATENCY];

  command_t             command;
  size_t                size;
  logic [LINE_BITS-1:0] line;
  logic                 in_range;
  logic                 accept;
  logic                 is_load;
  logic                 is_store;
  logic [3:0]           free_tag;
  logic [5:0]           shift;
  logic [63:0]          lane_mask;
  logic [63:0]          write_mask;
  logic [63:0]          write_data;
  logic [63:0]          read_line;

  always_comb begin
    command  = command_t'(proc2mem_command);
    size     = size_t'(proc2mem_size);
    line     = proc2mem_addr[3 +: LINE_BITS];
    in_range = {1'b0, proc2mem_addr} < ADDR_LIMIT;

    // Scan downward so the lowest-numbered free tag wins.
    free_tag = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      if (!busy[i]) free_tag = 4'(i);
    end

    accept   = !reset && in_range && (free_tag != 4'd0) &&
               (command == CMD_LOAD || command == CMD_STORE);
    is_load  = accept && (command == CMD_LOAD);
    is_store = accept && (command == CMD_STORE);
    mem2proc_response = accept ? free_tag : 4'd0;

    // Sub-line store data is right-justified; move it into its byte lanes.
    case (size)
      SIZE_BYTE: begin shift = {proc2mem_addr[2:0], 3'b000};  lane_mask = 64'h0000_0000_0000_00FF; end
      SIZE_HALF: begin shift = {proc2mem_addr[2:1], 4'b0000}; lane_mask = 64'h0000_0000_0000_FFFF; end
      SIZE_WORD: begin shift = {proc2mem_addr[2], 5'b00000};  lane_mask = 64'h0000_0000_FFFF_FFFF; end
      default:   begin shift = 6'd0;                          lane_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    write_mask = lane_mask << shift;
    write_data = (proc2mem_data << shift) & write_mask;
    read_line  = unified_memory[line];
  end

  // Storage survives reset; only accepted stores modify it.
  always_ff @(posedge clock) begin
    if (is_store) begin
      unified_memory[line] <= (read_line & ~write_mask) | write_data;
    end
  end

  // Completion delay line and tag pool; a completing tag frees at the end of its cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_tag[i]  <= 4'd0;
        pipe_data[i] <= 64'd0;
      end
    end else begin
      pipe_tag[0]  <= mem2proc_response;
      pipe_data[0] <= is_load ? read_line : 64'd0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      for (int i = 1; i <= 15; i++) begin
        if (mem2proc_tag == 4'(i)) busy[i] <= 1'b0;
        if (accept && free_tag == 4'(i)) busy[i] <= 1'b1;
      end
    end
  end

  assign mem2proc_tag  = pipe_tag[LATENCY-1];
  assign mem2proc_data = pipe_data[LATENCY-1];

endmodule

// File: tb/tb_bus_memory_model.sv
// Directed self-checking bench for bus_memory_model: per-cycle expected completions
// are scheduled from hand-computed responses and compared on every falling edge.
module tb_bus_memory_model;

  localparam int LATENCY   = 10;
  localparam int MEM_LINES = 8192;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;
  localparam logic [1:0] CMD_RSVD  = 2'd3;
  localparam logic [1:0] SZ_BYTE   = 2'd0;
  localparam logic [1:0] SZ_HALF   = 2'd1;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  proc2mem_command = 2'd0;
  logic [31:0] proc2mem_addr = 32'd0;
  logic [63:0] proc2mem_data = 64'd0;
  logic [1:0]  proc2mem_size = 2'd0;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   checking_on = 1'b0;
  logic [3:0]  exp_tag  [0:1023];
  logic [63:0] exp_data [0:1023];

  bus_memory_model #(.MEM_LINES(MEM_LINES), .LATENCY(LATENCY)) dut (
    .clock             (clock),
    .reset             (reset),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_size     (proc2mem_size),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, observed, expected);
    end
  endtask

  // Completion bus is checked every cycle; unscheduled cycles must be all zero.
  always @(negedge clock) begin
    if (checking_on) begin
      checkOutput("completion tag", 64'(mem2proc_tag), 64'(exp_tag[cyc]));
      checkOutput("completion data", mem2proc_data, exp_data[cyc]);
    end
  end

  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr,
                               input logic [63:0] data, input logic [1:0] size);
    @(posedge clock);
    #1;
    reset            = 1'b0;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = data;
    proc2mem_size    = size;
  endtask

  task automatic issue(input string name, input logic [1:0] cmd, input logic [31:0] addr,
                       input logic [63:0] data, input logic [1:0] size,
                       input logic [3:0] exp_resp, input logic [63:0] exp_line);
    applyStimulus(cmd, addr, data, size);
    #1;
    checkOutput(name, 64'(mem2proc_response), 64'(exp_resp));
    if (exp_resp != 4'd0) begin
      exp_tag[cyc + LATENCY]  = exp_resp;
      exp_data[cyc + LATENCY] = exp_line;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(CMD_NONE, 32'd0, 64'd0, SZ_BYTE);
  endtask

  task automatic doReset(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      reset            = 1'b1;
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = 32'h10;
      proc2mem_size    = SZ_DOUBLE;
      #1;
      checkOutput("response during reset", 64'(mem2proc_response), 64'd0);
      for (int k = cyc; k <= cyc + LATENCY + 2; k++) begin
        exp_tag[k]  = 4'd0;
        exp_data[k] = 64'd0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      exp_tag[k]  = 4'd0;
      exp_data[k] = 64'd0;
    end
    dut.unified_memory[0]    = 64'hCAFEF00D_12345678;
    dut.unified_memory[2]    = 64'h11223344_55667788;
    dut.unified_memory[4]    = 64'h01234567_89ABCDEF;
    dut.unified_memory[5]    = 64'h00000000_00000000;
    dut.unified_memory[6]    = 64'hFFFFFFFF_FFFFFFFF;
    dut.unified_memory[8191] = 64'h0F0E0D0C_0B0A0908;

    doReset(3);
    checking_on = 1'b1;

    // Single load with full latency.
    issue("load line2", CMD_LOAD, 32'h10, 64'd0, SZ_WORD, 4'd1, 64'h11223344_55667788);
    idle(11);

    // Byte store followed by a load of the same line next cycle.
    issue("store byte", CMD_STORE, 32'h13, 64'hAB, SZ_BYTE, 4'd1, 64'd0);
    issue("load after store", CMD_LOAD, 32'h10, 64'd0, SZ_BYTE, 4'd2, 64'h11223344_AB667788);
    idle(11);

    // Back-to-back loads: tag 1 frees after its completion cycle and is reissued.
    for (int i = 0; i < 12; i++) begin
      issue("burst load", CMD_LOAD, 32'h10, 64'd0, SZ_DOUBLE,
            (i < 11) ? 4'(i + 1) : 4'd1, 64'h11223344_AB667788);
    end
    idle(11);

    // Rejected requests must neither allocate tags nor alter memory.
    issue("load out of range", CMD_LOAD, 32'h0001_0000, 64'd0, SZ_DOUBLE, 4'd0, 64'd0);
    issue("command none", CMD_NONE, 32'h0, 64'hBAD, SZ_DOUBLE, 4'd0, 64'd0);
    issue("command reserved", CMD_RSVD, 32'h10, 64'hBAD, SZ_DOUBLE, 4'd0, 64'd0);
    issue("store out of range", CMD_STORE, 32'h0001_0000, 64'hBAD, SZ_DOUBLE, 4'd0, 64'd0);
    issue("store far address", CMD_STORE, 32'hFFFF_FFF8, 64'hBAD, SZ_DOUBLE, 4'd0, 64'd0);
    issue("load line0", CMD_LOAD, 32'h0, 64'd0, SZ_DOUBLE, 4'd1, 64'hCAFEF00D_12345678);
    issue("load last line", CMD_LOAD, 32'hFFF8, 64'd0, SZ_DOUBLE, 4'd2, 64'h0F0E0D0C_0B0A0908);
    issue("load last byte", CMD_LOAD, 32'hFFFF, 64'd0, SZ_BYTE, 4'd3, 64'h0F0E0D0C_0B0A0908);
    idle(11);

    // Reset with transactions in flight discards them and frees every tag.
    issue("pre-reset load 1", CMD_LOAD, 32'h10, 64'd0, SZ_DOUBLE, 4'd1, 64'h11223344_AB667788);
    issue("pre-reset load 2", CMD_LOAD, 32'h10, 64'd0, SZ_DOUBLE, 4'd2, 64'h11223344_AB667788);
    issue("pre-reset load 3", CMD_LOAD, 32'h10, 64'd0, SZ_DOUBLE, 4'd3, 64'h11223344_AB667788);
    idle(1);
    doReset(1);
    issue("post-reset load", CMD_LOAD, 32'h10, 64'd0, SZ_DOUBLE, 4'd1, 64'h11223344_AB667788);
    idle(11);

    // Lane placement for each store size, and load snapshots ignoring later stores.
    issue("store word", CMD_STORE, 32'h24, 64'hFFFFFFFF_DEADBEEF, SZ_WORD, 4'd1, 64'd0);
    issue("store half", CMD_STORE, 32'h2A, 64'hFFFFFFFF_FFFF1234, SZ_HALF, 4'd2, 64'd0);
    issue("store double", CMD_STORE, 32'h33, 64'h13579BDF_2468ACE0, SZ_DOUBLE, 4'd3, 64'd0);
    issue("load word line", CMD_LOAD, 32'h20, 64'd0, SZ_DOUBLE, 4'd4, 64'hDEADBEEF_89ABCDEF);
    issue("overwrite line4", CMD_STORE, 32'h20, 64'd0, SZ_DOUBLE, 4'd5, 64'd0);
    issue("load half line", CMD_LOAD, 32'h28, 64'd0, SZ_DOUBLE, 4'd6, 64'h00000000_12340000);
    issue("load double line", CMD_LOAD, 32'h30, 64'd0, SZ_DOUBLE, 4'd7, 64'h13579BDF_2468ACE0);
    issue("load cleared line", CMD_LOAD, 32'h20, 64'd0, SZ_DOUBLE, 4'd8, 64'd0);
    idle(12);

    checking_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
